// File: rtl/zif_cmd_sequencer_pkg.sv
// zif_seq_pkg: constants shared by the ZIF command sequencer.
//   OSC_MHZ / MAX_US : default oscillator frequency and largest delay
//   CMD_*            : command codes accepted on cmd_nr
//   state_t          : sequencer state encoding
package zif_seq_pkg;

  localparam int OSC_MHZ = 24;
  localparam int MAX_US  = 2730;

  localparam logic [7:0] CMD_NOP        = 8'h00;
  localparam logic [7:0] CMD_PROG_PULSE = 8'h01;
  localparam logic [7:0] CMD_READ       = 8'h02;
  localparam logic [7:0] CMD_VPP_ON     = 8'h03;
  localparam logic [7:0] CMD_VPP_OFF    = 8'h04;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    PULSE  = 3'd2,
    SAMPLE = 3'd3,
    SETTLE = 3'd4,
    DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/zif_cmd_sequencer_if.sv
// zif_cmd_sequencer_if: command/status bundle between the bus write domain
// and the sequencer.
//   cmd_run_sync  : run toggle from the writer
//   cmd_nr        : command number
//   pulse_us      : active-phase length in microseconds
//   settle_us     : settle-phase length in microseconds
//   cmd_run_async : finish toggle back to the writer
//   busy, err     : status
// master = bus writer side, slave = sequencer side.
interface zif_cmd_sequencer_if;
  logic        cmd_run_sync;
  logic [7:0]  cmd_nr;
  logic [11:0] pulse_us;
  logic [11:0] settle_us;
  logic        cmd_run_async;
  logic        busy;
  logic        err;

  modport master (
    output cmd_run_sync, cmd_nr, pulse_us, settle_us,
    input  cmd_run_async, busy, err
  );

  modport slave (
    input  cmd_run_sync, cmd_nr, pulse_us, settle_us,
    output cmd_run_async, busy, err
  );
endinterface

// File: rtl/zif_cmd_sequencer_delay.sv
// zif_seq_delay: loadable 16-bit phase down-counter.
//   osc, rst_n : clock, synchronous active-low reset
//   load       : load the counter from us (takes priority over counting)
//   us         : phase length in microseconds, clamped to MAX_US
//   done       : counter at zero (last cycle of the phase)
// A phase loaded with N cycles runs N cycles: load value is N-1 and the
// phase ends on the cycle the count reads zero. us=0 still yields one cycle.
module zif_seq_delay #(
  parameter int OSC_MHZ = zif_seq_pkg::OSC_MHZ,
  parameter int MAX_US  = zif_seq_pkg::MAX_US
) (
  input  logic        osc,
  input  logic        rst_n,
  input  logic        load,
  input  logic [11:0] us,
  output logic        done
);

  logic [15:0] count_q, count_d;
  logic [11:0] us_clamped;
  logic [15:0] cycles;
  logic [15:0] load_val;

  always_comb begin
    us_clamped = (us > 12'(MAX_US)) ? 12'(MAX_US) : us;
    cycles     = 16'(OSC_MHZ) * {4'd0, us_clamped};
    load_val   = (cycles == 16'd0) ? 16'd0 : cycles - 16'd1;
    count_d    = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != 16'd0) begin
      count_d = count_q - 16'd1;
    end
  end

  always_ff @(posedge osc) begin
    if (!rst_n) count_q <= 16'd0;
    else        count_q <= count_d;
  end

  assign done = (count_q == 16'd0);

endmodule

// File: rtl/zif_cmd_sequencer.sv
// zif_cmd_sequencer: sequences ZIF socket strobes for one bus command at a
// time, using a toggle handshake (cmd_run_sync / cmd_run_async).
//   osc       : clock (posedge)
//   rst_n     : synchronous active-low reset
//   bus       : command/status bundle (slave side)
//   prog_n    : program strobe, active low
//   oe_n      : output enable, active low
//   vpp_en    : VPP switch enable, persists across commands
//   sample_en : one-cycle read-data latch strobe
// Build option: ZIF_SEQ_VPP_INTERLOCK_EN rejects PROG_PULSE while vpp_en=0.
//
// state  | meaning
// IDLE   | waiting for a pending toggle
// DECODE | command latched, pick the phase sequence
// PULSE  | active phase (prog_n or oe_n low) for pulse_us
// SAMPLE | one cycle, sample_en high with oe_n still low
// SETTLE | strobes released, wait settle_us
// DONE   | return the finish toggle, drop busy
module zif_cmd_sequencer #(
  parameter int OSC_MHZ = zif_seq_pkg::OSC_MHZ,
  parameter int MAX_US  = zif_seq_pkg::MAX_US
) (
  input  logic                osc,
  input  logic                rst_n,
  zif_cmd_sequencer_if.slave  bus,
  output logic                prog_n,
  output logic                oe_n,
  output logic                vpp_en,
  output logic                sample_en
);
  import zif_seq_pkg::*;

  state_t      state_q, state_d;
  logic        sync1_q, sync2_q;
  logic [7:0]  cmd_q, cmd_d;
  logic [11:0] pulse_q, pulse_d;
  logic [11:0] settle_q, settle_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic        prog_n_q, prog_n_d;
  logic        oe_n_q, oe_n_d;
  logic        vpp_en_q, vpp_en_d;
  logic        sample_en_q, sample_en_d;
  logic        run_async_q, run_async_d;
  logic        timer_load, timer_done;
  logic [11:0] timer_us;
  logic        pending;
  logic        prog_blocked;

  assign pending = sync2_q ^ run_async_q;

`ifdef ZIF_SEQ_VPP_INTERLOCK_EN
  assign prog_blocked = ~vpp_en_q;
`else
  assign prog_blocked = 1'b0;
`endif

  zif_seq_delay #(.OSC_MHZ(OSC_MHZ), .MAX_US(MAX_US)) u_delay (
    .osc   (osc),
    .rst_n (rst_n),
    .load  (timer_load),
    .us    (timer_us),
    .done  (timer_done)
  );

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    pulse_d     = pulse_q;
    settle_d    = settle_q;
    busy_d      = busy_q;
    err_d       = err_q;
    prog_n_d    = prog_n_q;
    oe_n_d      = oe_n_q;
    vpp_en_d    = vpp_en_q;
    sample_en_d = 1'b0;
    run_async_d = run_async_q;
    timer_load  = 1'b0;
    timer_us    = pulse_q;
    case (state_q)
      IDLE: begin
        // Operands are captured on the edge into DECODE so later writes
        // to the bus registers cannot disturb a running command.
        if (pending) begin
          state_d  = DECODE;
          cmd_d    = bus.cmd_nr;
          pulse_d  = bus.pulse_us;
          settle_d = bus.settle_us;
          busy_d   = 1'b1;
          err_d    = 1'b0;
        end
      end
      DECODE: begin
        case (cmd_q)
          CMD_NOP: state_d = DONE;
          CMD_PROG_PULSE: begin
            if (prog_blocked) begin
              err_d   = 1'b1;
              state_d = DONE;
            end else begin
              prog_n_d   = 1'b0;
              timer_load = 1'b1;
              state_d    = PULSE;
            end
          end
          CMD_READ: begin
            oe_n_d     = 1'b0;
            timer_load = 1'b1;
            state_d    = PULSE;
          end
          CMD_VPP_ON, CMD_VPP_OFF: begin
            vpp_en_d   = (cmd_q == CMD_VPP_ON);
            timer_load = 1'b1;
            timer_us   = settle_q;
            state_d    = SETTLE;
          end
          default: begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        endcase
      end
      PULSE: begin
        if (timer_done) begin
          if (cmd_q == CMD_READ) begin
            sample_en_d = 1'b1;
            state_d     = SAMPLE;
          end else begin
            prog_n_d   = 1'b1;
            timer_load = 1'b1;
            timer_us   = settle_q;
            state_d    = SETTLE;
          end
        end
      end
      SAMPLE: begin
        oe_n_d     = 1'b1;
        timer_load = 1'b1;
        timer_us   = settle_q;
        state_d    = SETTLE;
      end
      SETTLE: begin
        if (timer_done) state_d = DONE;
      end
      DONE: begin
        // Absorbs any toggle that arrived while busy.
        run_async_d = sync2_q;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge osc) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      cmd_q       <= 8'd0;
      pulse_q     <= 12'd0;
      settle_q    <= 12'd0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      prog_n_q    <= 1'b1;
      oe_n_q      <= 1'b1;
      vpp_en_q    <= 1'b0;
      sample_en_q <= 1'b0;
      run_async_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= bus.cmd_run_sync;
      sync2_q     <= sync1_q;
      cmd_q       <= cmd_d;
      pulse_q     <= pulse_d;
      settle_q    <= settle_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      prog_n_q    <= prog_n_d;
      oe_n_q      <= oe_n_d;
      vpp_en_q    <= vpp_en_d;
      sample_en_q <= sample_en_d;
      run_async_q <= run_async_d;
    end
  end

  assign bus.cmd_run_async = run_async_q;
  assign bus.busy          = busy_q;
  assign bus.err           = err_q;
  assign prog_n            = prog_n_q;
  assign oe_n              = oe_n_q;
  assign vpp_en            = vpp_en_q;
  assign sample_en         = sample_en_q;

endmodule

// File: tb/tb_zif_cmd_sequencer.sv
// Bench for zif_cmd_sequencer: each issued command pushes its expected
// strobe/timing profile; the monitor pops it when the finish toggle arrives.
module tb_zif_cmd_sequencer;

  logic osc = 1'b0;
  logic rst_n;
  logic prog_n, oe_n, vpp_en, sample_en;

  always #5 osc = ~osc;

  zif_cmd_sequencer_if bus();

  zif_cmd_sequencer dut (
    .osc       (osc),
    .rst_n     (rst_n),
    .bus       (bus),
    .prog_n    (prog_n),
    .oe_n      (oe_n),
    .vpp_en    (vpp_en),
    .sample_en (sample_en)
  );

  typedef struct {
    int unsigned err;
    int unsigned busy_cyc;
    int unsigned prog_lo;
    int unsigned oe_lo;
    int unsigned smp;
    int unsigned vpp;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  bit   vpp_model = 1'b0;

  int unsigned busy_cnt = 0, prog_cnt = 0, oe_cnt = 0, smp_cnt = 0, ovl_cnt = 0;
  logic        async_prev = 1'b0;

  task automatic chk(string tag, int unsigned act, int unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int unsigned ph(int unsigned us);
    if (us == 0) return 1;
    return 24 * ((us > 2730) ? 2730 : us);
  endfunction

  // Monitor: accumulate per-command activity, score at the finish toggle.
  always @(negedge osc) begin
    if (!rst_n) begin
      busy_cnt = 0; prog_cnt = 0; oe_cnt = 0; smp_cnt = 0; ovl_cnt = 0;
      async_prev = bus.cmd_run_async;
    end else begin
      if (bus.busy)            busy_cnt++;
      if (!prog_n)             prog_cnt++;
      if (!oe_n)               oe_cnt++;
      if (sample_en)           smp_cnt++;
      if (!prog_n && !oe_n)    ovl_cnt++;
      if (bus.cmd_run_async !== async_prev) begin
        exp_t e;
        async_prev = bus.cmd_run_async;
        if (sb.size() == 0) begin
          chk("done_with_empty_sb", 32'(sb.size()), 1);
        end else begin
          e = sb.pop_front();
          chk("err",      32'(bus.err), e.err);
          chk("busy_cyc", busy_cnt, e.busy_cyc);
          chk("prog_lo",  prog_cnt, e.prog_lo);
          chk("oe_lo",    oe_cnt,   e.oe_lo);
          chk("sample",   smp_cnt,  e.smp);
          chk("vpp_en",   32'(vpp_en), e.vpp);
          chk("overlap",  ovl_cnt,  0);
          chk("busy_off", 32'(bus.busy), 0);
        end
        busy_cnt = 0; prog_cnt = 0; oe_cnt = 0; smp_cnt = 0; ovl_cnt = 0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(posedge osc); #1;
    while ((sb.size() != 0 || bus.busy) && n < 70000) begin
      @(posedge osc); #1;
      n++;
    end
    chk("idle_sb_empty", 32'(sb.size()), 0);
  endtask

  task automatic issue(logic [7:0] c, int unsigned p, int unsigned s);
    exp_t e;
    int   lat;
    bit   blocked;
    wait_idle();
    blocked = 1'b0;
`ifdef ZIF_SEQ_VPP_INTERLOCK_EN
    blocked = !vpp_model;
`endif
    e = '{err: 0, busy_cyc: 2, prog_lo: 0, oe_lo: 0, smp: 0, vpp: 0};
    case (c)
      8'h00: ;
      8'h01: begin
        if (blocked) e.err = 1;
        else begin
          e.prog_lo  = ph(p);
          e.busy_cyc = 2 + ph(p) + ph(s);
        end
      end
      8'h02: begin
        e.oe_lo    = ph(p) + 1;
        e.smp      = 1;
        e.busy_cyc = 3 + ph(p) + ph(s);
      end
      8'h03: begin vpp_model = 1'b1; e.busy_cyc = 2 + ph(s); end
      8'h04: begin vpp_model = 1'b0; e.busy_cyc = 2 + ph(s); end
      default: e.err = 1;
    endcase
    e.vpp = 32'(vpp_model);
    sb.push_back(e);
    bus.cmd_nr       = c;
    bus.pulse_us     = 12'(p);
    bus.settle_us    = 12'(s);
    bus.cmd_run_sync = ~bus.cmd_run_sync;
    lat = 0;
    while (!bus.busy && lat < 10) begin
      @(posedge osc); #1;
      lat++;
    end
    chk("accept_lat", 32'(lat), 3);
  endtask

  initial begin
    int n;
    rst_n            = 1'b0;
    bus.cmd_run_sync = 1'b0;
    bus.cmd_nr       = 8'd0;
    bus.pulse_us     = 12'd0;
    bus.settle_us    = 12'd0;
    repeat (3) @(posedge osc);
    #1;
    chk("rst_prog_n",    32'(prog_n), 1);
    chk("rst_oe_n",      32'(oe_n), 1);
    chk("rst_vpp_en",    32'(vpp_en), 0);
    chk("rst_sample_en", 32'(sample_en), 0);
    chk("rst_busy",      32'(bus.busy), 0);
    chk("rst_err",       32'(bus.err), 0);
    chk("rst_async",     32'(bus.cmd_run_async), 0);
    rst_n = 1'b1;

    issue(8'h00, 0, 0);
    issue(8'h03, 1, 0);

    // Second toggle mid-PULSE, then reset mid-PULSE.
    wait_idle();
    bus.cmd_nr       = 8'h01;
    bus.pulse_us     = 12'd10;
    bus.settle_us    = 12'd0;
    bus.cmd_run_sync = ~bus.cmd_run_sync;
    n = 0;
    while (prog_n && n < 100) begin @(posedge osc); #1; n++; end
    chk("mid_prog_low", 32'(prog_n), 0);
    repeat (100) @(posedge osc);
    #1;
    bus.cmd_run_sync = ~bus.cmd_run_sync;
    repeat (50) @(posedge osc);
    #1;
    chk("mid_still_low", 32'(prog_n), 0);
    rst_n = 1'b0;
    vpp_model = 1'b0;
    repeat (2) @(posedge osc);
    #1;
    chk("mid_rst_prog_n", 32'(prog_n), 1);
    chk("mid_rst_vpp_en", 32'(vpp_en), 0);
    chk("mid_rst_busy",   32'(bus.busy), 0);
    chk("mid_rst_oe_n",   32'(oe_n), 1);
    rst_n = 1'b1;
    repeat (20) @(posedge osc);
    #1;
    chk("no_rerun_busy",  32'(bus.busy), 0);
    chk("no_rerun_async", 32'(bus.cmd_run_async), 0);
    chk("no_rerun_prog",  32'(prog_cnt), 0);

    // Run flag still high when reset releases: executes as a new command.
    rst_n            = 1'b0;
    bus.cmd_run_sync = 1'b1;
    bus.cmd_nr       = 8'h00;
    sb.push_back('{err: 0, busy_cyc: 2, prog_lo: 0, oe_lo: 0, smp: 0, vpp: 0});
    repeat (2) @(posedge osc);
    #1;
    rst_n = 1'b1;

    issue(8'h02, 2, 1);
    issue(8'h01, 0, 0);
    issue(8'h7F, 5, 5);
    issue(8'h00, 0, 0);
    issue(8'h03, 0, 0);
    issue(8'h01, 0, 0);
    issue(8'h02, 0, 3);
    bus.cmd_nr   = 8'h55;
    bus.pulse_us = 12'd0;
    issue(8'h04, 2, 2);
    issue(8'h03, 0, 0);
    issue(8'h01, 4095, 0);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1);
  end

endmodule
